novacore_cfg_loader: RTL and testbench
======================================

Name: novacore_cfg_loader

Overview:
- Configuration transmitter for the NovaCORE fabric: the driving end of the fabric's configuration interface (`mode`, `c_bus`, `c_uid`, `c_clk`).
- Accepts (uid, data) configuration words on a valid/ready stream, e.g. from a host or ROM reader.
- Places each word on `c_bus`/`c_uid` and issues one `c_clk` pulse per word, framed by `mode`.
- Sits beside the fabric instance in the top level, clocked by the system clock.

Parameters:
- BUS_W, 42, width of `c_bus` (configuration data per unit).
- UID_W, 7, width of `c_uid` (unit address).
- NUM_UNITS, 25, number of addressable units; valid uids are 0..NUM_UNITS-1.
- CLK_DIV, 2, length of each `c_clk` phase (setup/high/hold) in clk cycles; legal range 1..255.
- CNT_W, 8, width of `word_count`.

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin configuration session; sampled only in IDLE
- abort  in  1  terminate the session early
- s_data  in  UID_W+BUS_W  word; [UID_W+BUS_W-1:BUS_W] is the uid, [BUS_W-1:0] is the data
- s_last  in  1  marks the final word of the session
- s_valid  in  1  word present
- s_ready  out  1  loader can accept a word
- mode  out  1  1 = fabric in configuration mode, 0 = run
- c_bus  out  BUS_W  configuration data
- c_uid  out  UID_W  target unit
- c_clk  out  1  configuration strobe; the fabric captures on its rising edge
- busy  out  1  session in progress (any state except IDLE)
- done  out  1  one-cycle pulse when the session ends
- err  out  1  sticky: an invalid uid was received in the current or last session
- word_count  out  CNT_W  words strobed into the fabric this session; saturates at all-ones

Behaviour:
- All outputs are registered.
- On rst=1: state is IDLE; mode, c_clk, s_ready, busy, done and err are 0; c_bus, c_uid and word_count are 0. rst overrides all other inputs.
- IDLE: start=1 moves to ENTER.
  - At that edge: mode<=1, busy<=1, err<=0, word_count<=0.
  - start while not in IDLE is ignored.
- ENTER: lasts CLK_DIV cycles with mode=1 and c_clk=0, then goes to WAIT.
- WAIT: s_ready=1. A word is accepted on the edge where s_valid=1 and s_ready=1; s_ready<=0 at that same edge.
  - Valid uid (uid < NUM_UNITS): c_uid and c_bus load from s_data at the accept edge; go to SETUP.
  - Invalid uid: c_bus and c_uid hold their values; err<=1; no strobe. Go to WAIT if s_last=0, else EXIT.
  - s_last is captured at accept.
- SETUP: CLK_DIV cycles with c_clk=0.
- PULSE: CLK_DIV cycles with c_clk=1. word_count increments on entry, saturating at all-ones.
- HOLD: CLK_DIV cycles with c_clk=0 and c_bus/c_uid stable. Then go to EXIT if the captured last flag is set, else WAIT.
- Per-word cost: 3*CLK_DIV+1 cycles with back-to-back s_valid. c_bus/c_uid change only at accept edges.
- EXIT: one cycle with mode=0, c_clk=0, done=1 and busy=1, then IDLE.
  - In IDLE: busy=0 and done=0; err and word_count hold until the next start.
- abort=1 in ENTER, WAIT, SETUP, PULSE or HOLD: the next state is EXIT, and c_clk<=0 and s_ready<=0 at that edge.
  - An abort during PULSE truncates the pulse; the word is still counted.
  - If abort and an accept coincide in WAIT, the abort wins: no accept takes place, and s_ready drops at that edge.
  - abort in IDLE or EXIT has no effect.
- A simultaneous start and abort in IDLE starts the session; abort is evaluated from ENTER onward.
- Phase counters are ceil(log2(CLK_DIV+1)) bits wide and restart at each state entry.
- rst asserted mid-session returns the block to reset values at the next edge. mode falls immediately, and done is not pulsed.

Test Plan:
- Reset: hold rst 3 cycles with start=1 and s_valid=1 -> mode=0, c_clk=0, s_ready=0, busy=0, done=0, word_count=0 on every cycle.
- Single word, CLK_DIV=2: start; at accept, s_data = uid 3 / data 42'h155, s_last=1.
  - ENTER lasts exactly 2 cycles before s_ready=1.
  - c_uid=3 and c_bus=42'h155 from the accept edge onward.
  - c_clk=0 for 2 cycles, then 1 for 2, then 0 for 2; then done=1 for 1 cycle with mode=0; word_count=1.
- Burst: 25 words with uid 0..24, s_valid held high, last on uid 24 -> exactly 25 `c_clk` rising edges.
  - Each rising edge sees the matching c_uid.
  - Accept-to-accept spacing is 7 cycles; word_count=25; err=0.
- Invalid uid: words uid 2, uid 30, uid 4 (last) -> 2 `c_clk` pulses; c_uid never shows 30; err=1 and word_count=2 after done; the next start clears err.
- Abort in PULSE after 1 cycle high -> c_clk=0 next cycle, then EXIT (done=1, mode=0), then IDLE; word_count=1.
- Stalls and ignored start: s_valid low for 10 cycles in WAIT -> s_ready stays 1, c_clk stays 0, mode stays 1; start pulsed mid-session -> no effect.

Source files
------------

// File: rtl/novacore_cfg_loader.sv
// Configuration transmitter: streams (uid, data) words into the fabric config port, one c_clk strobe per word.
// Latency: CLK_DIV-cycle mode lead-in, then 3*CLK_DIV+1 cycles per word, then a one-cycle EXIT with done.
// Backpressure: s_ready is high only in WAIT and drops at every accept until the word's strobe is complete.
module novacore_cfg_loader #(
    parameter int BUS_W     = 42,
    parameter int UID_W     = 7,
    parameter int NUM_UNITS = 25,
    parameter int CLK_DIV   = 2,
    parameter int CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [UID_W+BUS_W-1:0] s_data,
    input  logic                   s_last,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   mode,
    output logic [BUS_W-1:0]       c_bus,
    output logic [UID_W-1:0]       c_uid,
    output logic                   c_clk,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [CNT_W-1:0]       word_count
);

    localparam int PH_W = $clog2(CLK_DIV + 1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [UID_W:0]   NU_L    = (UID_W + 1)'(NUM_UNITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTER,
        S_WAIT,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_EXIT
    } state_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic               last_q, last_d;
    logic               mode_q, mode_d;
    logic               cclk_q, cclk_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [BUS_W-1:0]   bus_q, bus_d;
    logic [UID_W-1:0]   uid_q, uid_d;
    logic [CNT_W-1:0]   wc_q, wc_d;

    logic [UID_W-1:0]   s_uid;
    logic [BUS_W-1:0]   s_bus;
    logic               uid_ok;
    logic               ph_end;
    logic               in_session;

    assign s_uid      = s_data[UID_W+BUS_W-1:BUS_W];
    assign s_bus      = s_data[BUS_W-1:0];
    assign uid_ok     = ({1'b0, s_uid} < NU_L);
    assign ph_end     = (ph_q == PH_LAST);
    // Abort is honoured only while the fabric is actually held in configuration mode.
    assign in_session = (state_q != S_IDLE) && (state_q != S_EXIT);

    // Next-state and registered-output computation; abort pre-empts everything, including an accept.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q + PH_W'(1);
        last_d  = last_q;
        mode_d  = mode_q;
        cclk_d  = cclk_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        bus_d   = bus_q;
        uid_d   = uid_q;
        wc_d    = wc_q;
        if (abort && in_session) begin
            state_d = S_EXIT;
            ph_d    = '0;
            mode_d  = 1'b0;
            cclk_d  = 1'b0;
            rdy_d   = 1'b0;
            done_d  = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    ph_d = '0;
                    if (start) begin
                        state_d = S_ENTER;
                        mode_d  = 1'b1;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                        wc_d    = '0;
                    end
                end
                S_ENTER: begin
                    if (ph_end) begin
                        state_d = S_WAIT;
                        ph_d    = '0;
                        rdy_d   = 1'b1;
                    end
                end
                S_WAIT: begin
                    ph_d  = '0;
                    rdy_d = 1'b1;
                    if (s_valid && rdy_q) begin
                        rdy_d = 1'b0;
                        if (uid_ok) begin
                            uid_d   = s_uid;
                            bus_d   = s_bus;
                            last_d  = s_last;
                            state_d = S_SETUP;
                        end else begin
                            // Bad address: flag it, never strobe it, keep the bus untouched.
                            err_d = 1'b1;
                            if (s_last) begin
                                state_d = S_EXIT;
                                mode_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                S_SETUP: begin
                    if (ph_end) begin
                        state_d = S_PULSE;
                        ph_d    = '0;
                        cclk_d  = 1'b1;
                        wc_d    = (wc_q == {CNT_W{1'b1}}) ? wc_q : wc_q + CNT_W'(1);
                    end
                end
                S_PULSE: begin
                    if (ph_end) begin
                        state_d = S_HOLD;
                        ph_d    = '0;
                        cclk_d  = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (ph_end) begin
                        ph_d = '0;
                        if (last_q) begin
                            state_d = S_EXIT;
                            mode_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                            rdy_d   = 1'b1;
                        end
                    end
                end
                S_EXIT: begin
                    state_d = S_IDLE;
                    ph_d    = '0;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    ph_d    = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            last_q  <= 1'b0;
            mode_q  <= 1'b0;
            cclk_q  <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bus_q   <= '0;
            uid_q   <= '0;
            wc_q    <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
            cclk_q  <= cclk_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            bus_q   <= bus_d;
            uid_q   <= uid_d;
            wc_q    <= wc_d;
        end
    end

    assign s_ready    = rdy_q;
    assign mode       = mode_q;
    assign c_clk      = cclk_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign c_bus      = bus_q;
    assign c_uid      = uid_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_novacore_cfg_loader.sv
// Bench for novacore_cfg_loader: builds a per-cycle expected timeline for each session from word timing rules.
// Latency: checks every cycle, outputs sampled 1 time unit after the rising edge.
// Backpressure: stimulus holds words stable across s_ready low, as a legal stream source would.
module tb_novacore_cfg_loader;

    localparam int D    = 2;
    localparam int BW   = 42;
    localparam int UW   = 7;
    localparam int NU   = 25;
    localparam int CW   = 8;
    localparam int MAXL = 2200;

    logic              clk = 1'b0;
    logic              rst, start, abort, s_last, s_valid;
    logic [UW+BW-1:0]  s_data;
    logic              s_ready, mode, c_clk, busy, done, err;
    logic [BW-1:0]     c_bus;
    logic [UW-1:0]     c_uid;
    logic [CW-1:0]     word_count;

    always #5 clk = ~clk;

    novacore_cfg_loader #(
        .BUS_W(BW), .UID_W(UW), .NUM_UNITS(NU), .CLK_DIV(D), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .mode(mode), .c_bus(c_bus), .c_uid(c_uid), .c_clk(c_clk),
        .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    // Phase of the session after each edge k (k = 0 is the start edge).
    typedef enum int {P_IDLE, P_ENTER, P_WAIT, P_SETUP, P_PULSE, P_HOLD, P_EXIT} ph_t;
    ph_t             ph    [MAXL];
    bit              e_rdy [MAXL];
    logic [UW-1:0]   e_uid [MAXL];
    logic [BW-1:0]   e_bus [MAXL];
    bit              e_err [MAXL];
    int              e_wc  [MAXL];
    bit              i_start[MAXL], i_abort[MAXL], i_valid[MAXL], i_last[MAXL];
    logic [UW+BW-1:0] i_data[MAXL];

    int              nw;
    logic [UW-1:0]   w_uid  [300];
    logic [BW-1:0]   w_dat  [300];
    int              w_gap  [300];
    bit              w_early[300];

    logic [UW-1:0]   carry_uid = '0;
    logic [BW-1:0]   carry_bus = '0;
    int              sess_len, sess_end;
    int              n_checks = 0, n_pass = 0;
    int              cur_k = 0;
    bit              chk_en = 1'b0;
    int              rises = 0;
    bit              cclk_prev = 1'b0;

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0d: got %0h expected %0h", nm, k, act, exp);
    endtask

    task automatic set_vals(input int k, input logic [UW-1:0] u, input logic [BW-1:0] b,
                            input bit e, input int w);
        for (int j = k; j < MAXL; j++) begin
            e_uid[j] = u; e_bus[j] = b; e_err[j] = e; e_wc[j] = w;
        end
    endtask

    // Expected timeline: ENTER for D edges, each word accepted one edge after ready appears,
    // then D setup + D high + D hold edges; a bad uid costs one ready-low edge and no strobe.
    // ab_sel: -1 no abort, 0 random abort edge, >0 abort at that edge.
    task automatic build(input int ab_sel, input bit stray);
        int w, a, p, E, ab, pad, cw, L;
        logic [UW-1:0] cu;
        logic [BW-1:0] cb;
        bit ce;
        for (int j = 0; j < MAXL; j++) begin
            ph[j] = P_IDLE; e_rdy[j] = 0; i_start[j] = 0; i_abort[j] = 0;
            i_valid[j] = 0; i_last[j] = 0;
            i_data[j] = (UW+BW)'({$urandom(), $urandom()});
        end
        cu = carry_uid; cb = carry_bus; ce = 0; cw = 0; E = 0;
        set_vals(0, cu, cb, 0, 0);
        i_start[0] = 1;
        for (int j = 0; j < D; j++) ph[j] = P_ENTER;
        ph[D] = P_WAIT; e_rdy[D] = 1;
        w = D + 1; p = 0;
        for (int i = 0; i < nw; i++) begin
            if (w_early[i]) begin
                a = w;
                for (int j = p; j <= a; j++) begin
                    i_valid[j] = 1; i_data[j] = {w_uid[i], w_dat[i]}; i_last[j] = (i == nw - 1);
                end
            end else begin
                a = w + w_gap[i];
                for (int j = w; j < a; j++) begin ph[j] = P_WAIT; e_rdy[j] = 1; end
                i_valid[a] = 1; i_data[a] = {w_uid[i], w_dat[i]}; i_last[a] = (i == nw - 1);
            end
            if (w_uid[i] < NU) begin
                cu = w_uid[i]; cb = w_dat[i];
                set_vals(a, cu, cb, ce, cw);
                for (int j = 0; j < D; j++) begin
                    ph[a + j] = P_SETUP; ph[a + D + j] = P_PULSE; ph[a + 2*D + j] = P_HOLD;
                end
                if (cw < 255) cw++;
                set_vals(a + D, cu, cb, ce, cw);
                if (i == nw - 1) E = a + 3*D;
                else begin ph[a + 3*D] = P_WAIT; e_rdy[a + 3*D] = 1; w = a + 3*D + 1; end
            end else begin
                ce = 1;
                set_vals(a, cu, cb, ce, cw);
                if (i == nw - 1) E = a;
                else begin
                    ph[a] = P_WAIT; e_rdy[a] = 0; ph[a + 1] = P_WAIT; e_rdy[a + 1] = 1; w = a + 2;
                end
            end
            p = a + 1;
        end
        ph[E] = P_EXIT;
        if (ab_sel >= 0) begin
            ab = (ab_sel == 0) ? int'($urandom_range(E, 1)) : ab_sel;
            set_vals(ab, e_uid[ab-1], e_bus[ab-1], e_err[ab-1], e_wc[ab-1]);
            for (int j = ab; j < MAXL; j++) begin
                ph[j] = P_IDLE; e_rdy[j] = 0;
                if (j > ab) i_valid[j] = 0;
            end
            ph[ab] = P_EXIT; i_abort[ab] = 1; E = ab;
        end
        pad = $urandom_range(5, 2);
        L = E + 2 + pad;
        for (int j = E + 1; j < L; j++) begin
            i_valid[j] = $urandom_range(1, 0); i_abort[j] = $urandom_range(1, 0);
            i_last[j] = $urandom_range(1, 0);
        end
        if (stray) i_start[$urandom_range(E + 1, 1)] = 1;
        sess_len = L; sess_end = E;
        carry_uid = e_uid[L-1]; carry_bus = e_bus[L-1];
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            start = i_start[k]; abort = i_abort[k]; s_valid = i_valid[k];
            s_data = i_data[k]; s_last = i_last[k];
            cur_k = k; chk_en = 1;
        end
        @(negedge clk);
        chk_en = 0; start = 0; abort = 0; s_valid = 0; s_last = 0;
    endtask

    task automatic compare(input int k);
        ph_t q;
        q = ph[k];
        chk("mode", k, 64'(mode), 64'(q == P_ENTER || q == P_WAIT || q == P_SETUP || q == P_PULSE || q == P_HOLD));
        chk("c_clk", k, 64'(c_clk), 64'(q == P_PULSE));
        chk("busy", k, 64'(busy), 64'(q != P_IDLE));
        chk("done", k, 64'(done), 64'(q == P_EXIT));
        chk("s_ready", k, 64'(s_ready), 64'(e_rdy[k]));
        chk("c_uid", k, 64'(c_uid), 64'(e_uid[k]));
        chk("c_bus", k, 64'(c_bus), 64'(e_bus[k]));
        chk("err", k, 64'(err), 64'(e_err[k]));
        chk("word_count", k, 64'(word_count), 64'(e_wc[k]));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_mode"}, 0, 64'(mode), 64'(0));
        chk({nm, "_c_clk"}, 0, 64'(c_clk), 64'(0));
        chk({nm, "_s_ready"}, 0, 64'(s_ready), 64'(0));
        chk({nm, "_busy"}, 0, 64'(busy), 64'(0));
        chk({nm, "_done"}, 0, 64'(done), 64'(0));
        chk({nm, "_err"}, 0, 64'(err), 64'(0));
        chk({nm, "_wc"}, 0, 64'(word_count), 64'(0));
        chk({nm, "_c_uid"}, 0, 64'(c_uid), 64'(0));
        chk({nm, "_c_bus"}, 0, 64'(c_bus), 64'(0));
    endtask

    // Per-cycle comparison against the expected timeline.
    always @(posedge clk) begin
        #1;
        if (chk_en) compare(cur_k);
    end

    // Counts rising edges of c_clk as seen by the fabric.
    always @(posedge clk) begin
        #1;
        if (c_clk && !cclk_prev) rises++;
        cclk_prev = c_clk;
    end

    task automatic one_word(input logic [UW-1:0] u, input logic [BW-1:0] d, input bit early, input int gap);
        nw = 1; w_uid[0] = u; w_dat[0] = d; w_early[0] = early; w_gap[0] = gap;
    endtask

    task automatic rand_words(input int n, input int max_uid);
        nw = n;
        for (int i = 0; i < n; i++) begin
            w_uid[i]   = UW'($urandom_range(max_uid, 0));
            w_dat[i]   = BW'({$urandom(), $urandom()});
            w_early[i] = $urandom_range(1, 0);
            w_gap[i]   = $urandom_range(3, 0);
        end
    endtask

    initial begin
        rst = 1; start = 1; abort = 0; s_valid = 1; s_last = 0;
        s_data = (UW+BW)'({$urandom(), $urandom()});
        repeat (3) begin
            @(posedge clk); #1;
            chk_zero("reset");
        end
        @(negedge clk);
        rst = 0; start = 0; s_valid = 0;
        carry_uid = '0; carry_bus = '0;

        // Single word, uid 3 / 42'h155.
        one_word(7'd3, 42'h155, 1, 0);
        build(-1, 0);
        chk("model_single_end", 0, 64'(sess_end), 64'(9));
        rises = 0;
        run(sess_len);
        chk("single_wc", 0, 64'(word_count), 64'(1));
        chk("single_uid", 0, 64'(c_uid), 64'(3));
        chk("single_bus", 0, 64'(c_bus), 64'h155);
        chk("single_rises", 0, 64'(rises), 64'(1));

        // Burst over every unit with s_valid held high.
        nw = 25;
        for (int i = 0; i < 25; i++) begin
            w_uid[i] = UW'(i); w_dat[i] = BW'({$urandom(), $urandom()}); w_early[i] = 1; w_gap[i] = 0;
        end
        build(-1, 0);
        chk("model_burst_end", 0, 64'(sess_end), 64'(177));
        rises = 0;
        run(sess_len);
        chk("burst_rises", 0, 64'(rises), 64'(25));
        chk("burst_wc", 0, 64'(word_count), 64'(25));
        chk("burst_err", 0, 64'(err), 64'(0));

        // Invalid uid in the middle of a session.
        nw = 3;
        w_uid[0] = 7'd2;  w_uid[1] = 7'd30; w_uid[2] = 7'd4;
        for (int i = 0; i < 3; i++) begin
            w_dat[i] = BW'({$urandom(), $urandom()}); w_early[i] = 1; w_gap[i] = 0;
        end
        build(-1, 0);
        chk("model_inval_end", 0, 64'(sess_end), 64'(18));
        rises = 0;
        run(sess_len);
        chk("inval_rises", 0, 64'(rises), 64'(2));
        chk("inval_err", 0, 64'(err), 64'(1));
        chk("inval_wc", 0, 64'(word_count), 64'(2));
        chk("inval_uid", 0, 64'(c_uid), 64'(4));

        // Next session clears err; abort one cycle into the pulse.
        one_word(7'd5, 42'h2AA_0000_1234, 1, 0);
        build(6, 0);
        chk("model_abort_wc", 0, 64'(e_wc[6]), 64'(1));
        rises = 0;
        run(sess_len);
        chk("abort_wc", 0, 64'(word_count), 64'(1));
        chk("abort_rises", 0, 64'(rises), 64'(1));
        chk("abort_err", 0, 64'(err), 64'(0));

        // Stall in WAIT plus a stray start mid-session.
        one_word(7'd17, 42'h3_0F0F_0F0F, 0, 10);
        build(-1, 1);
        chk("model_stall_end", 0, 64'(sess_end), 64'(19));
        run(sess_len);

        // Randomized sessions.
        for (int s = 0; s < 16; s++) begin
            rand_words($urandom_range(8, 1), 29);
            build(($urandom_range(9, 0) < 3) ? 0 : -1, $urandom_range(9, 0) < 3);
            run(sess_len);
        end

        // Saturation of word_count.
        rand_words(260, NU - 1);
        for (int i = 0; i < 260; i++) begin w_early[i] = 1; w_gap[i] = 0; end
        build(-1, 0);
        chk("model_sat_wc", 0, 64'(e_wc[sess_end]), 64'(255));
        run(sess_len);
        chk("sat_wc", 0, 64'(word_count), 64'(255));

        // Reset in the middle of a session.
        rand_words(3, NU - 1);
        build(-1, 0);
        run(8);
        rst = 1;
        @(posedge clk); #1;
        chk_zero("midrst");
        @(negedge clk);
        rst = 0;
        carry_uid = '0; carry_bus = '0;
        rand_words(4, 29);
        build(-1, 0);
        run(sess_len);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
